// File: rtl/eth_type_demux.sv
// Ethertype steering stage: accepts one Ethernet frame at a time and forwards it whole to the
// ARP or IPv4 receive output, or sinks it when the ethertype matches neither.
module eth_type_demux #(
  parameter int          DATA_WIDTH  = 8,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int          KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter logic [15:0] ARP_TYPE    = 16'h0806,
  parameter logic [15:0] IP_TYPE     = 16'h0800
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,

  output logic                  m_arp_eth_hdr_valid,
  input  logic                  m_arp_eth_hdr_ready,
  output logic [47:0]           m_arp_eth_dest_mac,
  output logic [47:0]           m_arp_eth_src_mac,
  output logic [15:0]           m_arp_eth_type,
  output logic [DATA_WIDTH-1:0] m_arp_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_arp_eth_payload_axis_tkeep,
  output logic                  m_arp_eth_payload_axis_tvalid,
  input  logic                  m_arp_eth_payload_axis_tready,
  output logic                  m_arp_eth_payload_axis_tlast,
  output logic                  m_arp_eth_payload_axis_tuser,

  output logic                  m_ip_eth_hdr_valid,
  input  logic                  m_ip_eth_hdr_ready,
  output logic [47:0]           m_ip_eth_dest_mac,
  output logic [47:0]           m_ip_eth_src_mac,
  output logic [15:0]           m_ip_eth_type,
  output logic [DATA_WIDTH-1:0] m_ip_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_ip_eth_payload_axis_tkeep,
  output logic                  m_ip_eth_payload_axis_tvalid,
  input  logic                  m_ip_eth_payload_axis_tready,
  output logic                  m_ip_eth_payload_axis_tlast,
  output logic                  m_ip_eth_payload_axis_tuser,

  output logic                  drop_frame,
  output logic [1:0]            state_dbg
);

  // Handshakes: a header or payload beat transfers on a rising edge where valid && ready are both 1;
  // valid never waits on ready, and a presented header holds its fields stable until it transfers.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FWD_ARP = 2'd1,
    FWD_IP  = 2'd2,
    DROP    = 2'd3
  } state_t;

  state_t state, state_next;

  logic [47:0]           dest_mac_reg;
  logic [47:0]           src_mac_reg;
  logic [15:0]           type_reg;
  logic                  arp_hdr_valid_reg;
  logic                  ip_hdr_valid_reg;
  logic                  drop_frame_reg;
  logic                  hdr_accept;
  logic                  is_arp;
  logic                  is_ip;
  logic [KEEP_WIDTH-1:0] keep_int;

  // A new header waits for both the previous frame's tail and the previous output header.
  assign s_eth_hdr_ready = !rst && (state == IDLE) && !arp_hdr_valid_reg && !ip_hdr_valid_reg;
  assign hdr_accept      = s_eth_hdr_valid && s_eth_hdr_ready;
  assign is_arp          = (s_eth_type == ARP_TYPE);
  assign is_ip           = (s_eth_type == IP_TYPE);

  always_comb begin
    state_next                    = state;
    s_eth_payload_axis_tready     = 1'b0;
    m_arp_eth_payload_axis_tvalid = 1'b0;
    m_ip_eth_payload_axis_tvalid  = 1'b0;
    case (state)
      IDLE: begin
        if (hdr_accept) begin
          if (is_arp)     state_next = FWD_ARP;
          else if (is_ip) state_next = FWD_IP;
          else            state_next = DROP;
        end
      end
      FWD_ARP: begin
        m_arp_eth_payload_axis_tvalid = s_eth_payload_axis_tvalid;
        s_eth_payload_axis_tready     = m_arp_eth_payload_axis_tready;
      end
      FWD_IP: begin
        m_ip_eth_payload_axis_tvalid = s_eth_payload_axis_tvalid;
        s_eth_payload_axis_tready    = m_ip_eth_payload_axis_tready;
      end
      DROP: begin
        s_eth_payload_axis_tready = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    if (state != IDLE && s_eth_payload_axis_tvalid && s_eth_payload_axis_tready &&
        s_eth_payload_axis_tlast) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      arp_hdr_valid_reg <= 1'b0;
      ip_hdr_valid_reg  <= 1'b0;
      drop_frame_reg    <= 1'b0;
    end else begin
      state             <= state_next;
      arp_hdr_valid_reg <= (arp_hdr_valid_reg && !m_arp_eth_hdr_ready) || (hdr_accept && is_arp);
      ip_hdr_valid_reg  <= (ip_hdr_valid_reg && !m_ip_eth_hdr_ready) || (hdr_accept && is_ip);
      drop_frame_reg    <= hdr_accept && !is_arp && !is_ip;
    end
  end

  // Header fields are shared by both outputs; only one header can be pending at a time.
  always_ff @(posedge clk) begin
    if (hdr_accept) begin
      dest_mac_reg <= s_eth_dest_mac;
      src_mac_reg  <= s_eth_src_mac;
      type_reg     <= s_eth_type;
    end
  end

  generate
    if (KEEP_ENABLE) begin : g_keep
      assign keep_int = s_eth_payload_axis_tkeep;
    end else begin : g_no_keep
      assign keep_int = '1;
    end
  endgenerate

  assign m_arp_eth_hdr_valid          = arp_hdr_valid_reg;
  assign m_arp_eth_dest_mac           = dest_mac_reg;
  assign m_arp_eth_src_mac            = src_mac_reg;
  assign m_arp_eth_type               = type_reg;
  assign m_arp_eth_payload_axis_tdata = s_eth_payload_axis_tdata;
  assign m_arp_eth_payload_axis_tkeep = keep_int;
  assign m_arp_eth_payload_axis_tlast = s_eth_payload_axis_tlast;
  assign m_arp_eth_payload_axis_tuser = s_eth_payload_axis_tuser;

  assign m_ip_eth_hdr_valid           = ip_hdr_valid_reg;
  assign m_ip_eth_dest_mac            = dest_mac_reg;
  assign m_ip_eth_src_mac             = src_mac_reg;
  assign m_ip_eth_type                = type_reg;
  assign m_ip_eth_payload_axis_tdata  = s_eth_payload_axis_tdata;
  assign m_ip_eth_payload_axis_tkeep  = keep_int;
  assign m_ip_eth_payload_axis_tlast  = s_eth_payload_axis_tlast;
  assign m_ip_eth_payload_axis_tuser  = s_eth_payload_axis_tuser;

  assign drop_frame = drop_frame_reg;
  assign state_dbg  = state;

endmodule

// File: tb/tb_eth_type_demux.sv
// Randomized bench for eth_type_demux: frames are routed by a reference model into per-output
// expected queues, and a monitor pops and compares every header and payload transfer.
module tb_eth_type_demux;

  logic        clk = 1'b0;
  logic        rst;

  logic        s_eth_hdr_valid;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac;
  logic [47:0] s_eth_src_mac;
  logic [15:0] s_eth_type;
  logic [7:0]  s_eth_payload_axis_tdata;
  logic [0:0]  s_eth_payload_axis_tkeep;
  logic        s_eth_payload_axis_tvalid;
  logic        s_eth_payload_axis_tready;
  logic        s_eth_payload_axis_tlast;
  logic        s_eth_payload_axis_tuser;

  logic        m_arp_eth_hdr_valid, m_arp_eth_hdr_ready;
  logic [47:0] m_arp_eth_dest_mac, m_arp_eth_src_mac;
  logic [15:0] m_arp_eth_type;
  logic [7:0]  m_arp_eth_payload_axis_tdata;
  logic [0:0]  m_arp_eth_payload_axis_tkeep;
  logic        m_arp_eth_payload_axis_tvalid, m_arp_eth_payload_axis_tready;
  logic        m_arp_eth_payload_axis_tlast, m_arp_eth_payload_axis_tuser;

  logic        m_ip_eth_hdr_valid, m_ip_eth_hdr_ready;
  logic [47:0] m_ip_eth_dest_mac, m_ip_eth_src_mac;
  logic [15:0] m_ip_eth_type;
  logic [7:0]  m_ip_eth_payload_axis_tdata;
  logic [0:0]  m_ip_eth_payload_axis_tkeep;
  logic        m_ip_eth_payload_axis_tvalid, m_ip_eth_payload_axis_tready;
  logic        m_ip_eth_payload_axis_tlast, m_ip_eth_payload_axis_tuser;

  logic        drop_frame;
  logic [1:0]  state_dbg;

  // Scoreboard state: headers as {dest, src, type}, payload beats as {tlast, tuser, tdata}.
  logic [111:0] exp_arp_hdr_q[$];
  logic [111:0] exp_ip_hdr_q[$];
  logic [9:0]   exp_arp_q[$];
  logic [9:0]   exp_ip_q[$];
  int n_vec = 0;
  int n_err = 0;
  int drop_exp = 0;
  int drop_seen = 0;
  bit arp_hdr_hold = 1'b0;
  bit ip_toggle = 1'b0;

  eth_type_demux dut (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
    .s_eth_payload_axis_tdata(s_eth_payload_axis_tdata),
    .s_eth_payload_axis_tkeep(s_eth_payload_axis_tkeep),
    .s_eth_payload_axis_tvalid(s_eth_payload_axis_tvalid),
    .s_eth_payload_axis_tready(s_eth_payload_axis_tready),
    .s_eth_payload_axis_tlast(s_eth_payload_axis_tlast),
    .s_eth_payload_axis_tuser(s_eth_payload_axis_tuser),
    .m_arp_eth_hdr_valid(m_arp_eth_hdr_valid), .m_arp_eth_hdr_ready(m_arp_eth_hdr_ready),
    .m_arp_eth_dest_mac(m_arp_eth_dest_mac), .m_arp_eth_src_mac(m_arp_eth_src_mac),
    .m_arp_eth_type(m_arp_eth_type),
    .m_arp_eth_payload_axis_tdata(m_arp_eth_payload_axis_tdata),
    .m_arp_eth_payload_axis_tkeep(m_arp_eth_payload_axis_tkeep),
    .m_arp_eth_payload_axis_tvalid(m_arp_eth_payload_axis_tvalid),
    .m_arp_eth_payload_axis_tready(m_arp_eth_payload_axis_tready),
    .m_arp_eth_payload_axis_tlast(m_arp_eth_payload_axis_tlast),
    .m_arp_eth_payload_axis_tuser(m_arp_eth_payload_axis_tuser),
    .m_ip_eth_hdr_valid(m_ip_eth_hdr_valid), .m_ip_eth_hdr_ready(m_ip_eth_hdr_ready),
    .m_ip_eth_dest_mac(m_ip_eth_dest_mac), .m_ip_eth_src_mac(m_ip_eth_src_mac),
    .m_ip_eth_type(m_ip_eth_type),
    .m_ip_eth_payload_axis_tdata(m_ip_eth_payload_axis_tdata),
    .m_ip_eth_payload_axis_tkeep(m_ip_eth_payload_axis_tkeep),
    .m_ip_eth_payload_axis_tvalid(m_ip_eth_payload_axis_tvalid),
    .m_ip_eth_payload_axis_tready(m_ip_eth_payload_axis_tready),
    .m_ip_eth_payload_axis_tlast(m_ip_eth_payload_axis_tlast),
    .m_ip_eth_payload_axis_tuser(m_ip_eth_payload_axis_tuser),
    .drop_frame(drop_frame), .state_dbg(state_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [111:0] act, input logic [111:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for handshake", name);
    report();
  endtask

  // Reference routing: 0 = ARP output, 1 = IP output, 2 = dropped.
  function automatic int route_of(input logic [15:0] t);
    if (t == 16'h0806) return 0;
    if (t == 16'h0800) return 1;
    return 2;
  endfunction

  // Downstream sinks
  initial begin
    m_arp_eth_hdr_ready = 1'b0;
    m_ip_eth_hdr_ready = 1'b0;
    m_arp_eth_payload_axis_tready = 1'b0;
    m_ip_eth_payload_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_arp_eth_hdr_ready = arp_hdr_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      m_ip_eth_hdr_ready = ($urandom_range(0, 3) != 0);
      m_arp_eth_payload_axis_tready = ($urandom_range(0, 3) != 0);
      m_ip_eth_payload_axis_tready = ip_toggle ? !m_ip_eth_payload_axis_tready
                                               : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: spurious-valid checks run before pops so a final beat is not flagged.
  always @(negedge clk) begin
    if (!rst) begin
      chk_bit("arp_spurious_tvalid", m_arp_eth_payload_axis_tvalid && exp_arp_q.size() == 0, 1'b0);
      chk_bit("ip_spurious_tvalid", m_ip_eth_payload_axis_tvalid && exp_ip_q.size() == 0, 1'b0);
      if (m_arp_eth_hdr_valid && m_arp_eth_hdr_ready) begin
        if (exp_arp_hdr_q.size() == 0) chk_bit("arp_hdr_unexpected", m_arp_eth_hdr_valid, 1'b0);
        else chk_vec("arp_hdr", {m_arp_eth_dest_mac, m_arp_eth_src_mac, m_arp_eth_type},
                     exp_arp_hdr_q.pop_front());
      end
      if (m_ip_eth_hdr_valid && m_ip_eth_hdr_ready) begin
        if (exp_ip_hdr_q.size() == 0) chk_bit("ip_hdr_unexpected", m_ip_eth_hdr_valid, 1'b0);
        else chk_vec("ip_hdr", {m_ip_eth_dest_mac, m_ip_eth_src_mac, m_ip_eth_type},
                     exp_ip_hdr_q.pop_front());
      end
      if (m_arp_eth_payload_axis_tvalid && m_arp_eth_payload_axis_tready && exp_arp_q.size() != 0) begin
        chk_vec("arp_beat", 112'({m_arp_eth_payload_axis_tlast, m_arp_eth_payload_axis_tuser,
                                  m_arp_eth_payload_axis_tdata}), 112'(exp_arp_q.pop_front()));
        chk_bit("arp_tkeep", m_arp_eth_payload_axis_tkeep[0], 1'b1);
      end
      if (m_ip_eth_payload_axis_tvalid && m_ip_eth_payload_axis_tready && exp_ip_q.size() != 0) begin
        chk_vec("ip_beat", 112'({m_ip_eth_payload_axis_tlast, m_ip_eth_payload_axis_tuser,
                                 m_ip_eth_payload_axis_tdata}), 112'(exp_ip_q.pop_front()));
        chk_bit("ip_tkeep", m_ip_eth_payload_axis_tkeep[0], 1'b1);
      end
      if (drop_frame) drop_seen++;
    end
  end

  // Driver: presents a header, checks the one-cycle header latency, then streams the payload.
  // rst_at >= 0 asserts reset in place of that payload beat.
  task automatic send_frame(input logic [15:0] typ, input int len, input logic user_last,
                            input int rst_at);
    logic [47:0] dmac;
    logic [47:0] smac;
    int route;
    int t;
    dmac = {16'($urandom), $urandom};
    smac = {16'($urandom), $urandom};
    route = route_of(typ);
    if (route == 0) exp_arp_hdr_q.push_back({dmac, smac, typ});
    else if (route == 1) exp_ip_hdr_q.push_back({dmac, smac, typ});
    else drop_exp++;
    s_eth_hdr_valid = 1'b1;
    s_eth_dest_mac = dmac;
    s_eth_src_mac = smac;
    s_eth_type = typ;
    t = 0;
    @(negedge clk);
    while (!s_eth_hdr_ready) begin
      if (t > 300) timeout("hdr_accept");
      t++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_eth_hdr_valid = 1'b0;
    @(negedge clk);
    chk_bit("arp_hdr_valid_latency", m_arp_eth_hdr_valid, route == 0);
    chk_bit("ip_hdr_valid_latency", m_ip_eth_hdr_valid, route == 1);
    chk_bit("drop_frame_pulse", drop_frame, route == 2);
    @(posedge clk);
    #1;
    for (int i = 0; i < len; i++) begin
      if (i == rst_at) begin
        s_eth_payload_axis_tvalid = 1'b0;
        rst = 1'b1;
        exp_arp_hdr_q.delete();
        exp_ip_hdr_q.delete();
        exp_arp_q.delete();
        exp_ip_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_bit("rst_arp_hdr_valid", m_arp_eth_hdr_valid, 1'b0);
        chk_bit("rst_ip_hdr_valid", m_ip_eth_hdr_valid, 1'b0);
        chk_bit("rst_ip_tvalid", m_ip_eth_payload_axis_tvalid, 1'b0);
        chk_bit("rst_s_tready", s_eth_payload_axis_tready, 1'b0);
        chk_vec("rst_state_idle", 112'(state_dbg), 112'(0));
        @(posedge clk);
        #1;
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      s_eth_payload_axis_tdata = 8'($urandom);
      s_eth_payload_axis_tlast = (i == len - 1);
      s_eth_payload_axis_tuser = user_last && (i == len - 1);
      if (route == 0) exp_arp_q.push_back({s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
                                           s_eth_payload_axis_tdata});
      if (route == 1) exp_ip_q.push_back({s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
                                          s_eth_payload_axis_tdata});
      s_eth_payload_axis_tvalid = 1'b1;
      @(negedge clk);
      if (route == 2) chk_bit("drop_tready", s_eth_payload_axis_tready, 1'b1);
      t = 0;
      while (!s_eth_payload_axis_tready) begin
        if (t > 300) timeout("payload_beat");
        t++;
        @(negedge clk);
      end
      @(posedge clk);
      #1;
      s_eth_payload_axis_tvalid = 1'b0;
      s_eth_payload_axis_tlast = 1'b0;
      s_eth_payload_axis_tuser = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] typ;
    int t;
    rst = 1'b1;
    s_eth_hdr_valid = 1'b0;
    s_eth_dest_mac = '0;
    s_eth_src_mac = '0;
    s_eth_type = '0;
    s_eth_payload_axis_tdata = '0;
    s_eth_payload_axis_tkeep = 1'b1;
    s_eth_payload_axis_tvalid = 1'b0;
    s_eth_payload_axis_tlast = 1'b0;
    s_eth_payload_axis_tuser = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_bit("reset_hdr_ready", s_eth_hdr_ready, 1'b0);
    chk_bit("reset_s_tready", s_eth_payload_axis_tready, 1'b0);
    chk_bit("reset_arp_hdr_valid", m_arp_eth_hdr_valid, 1'b0);
    chk_bit("reset_ip_hdr_valid", m_ip_eth_hdr_valid, 1'b0);
    chk_bit("reset_drop_frame", drop_frame, 1'b0);
    chk_vec("reset_state_idle", 112'(state_dbg), 112'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed frames
    send_frame(16'h0806, 28, 1'b0, -1);
    ip_toggle = 1'b1;
    send_frame(16'h0800, 60, 1'b0, -1);
    ip_toggle = 1'b0;
    send_frame(16'h86DD, 40, 1'b0, -1);

    // ARP header held downstream blocks the next header even after the ARP payload ends
    arp_hdr_hold = 1'b1;
    send_frame(16'h0806, 8, 1'b0, -1);
    s_eth_hdr_valid = 1'b1;
    s_eth_type = 16'h0800;
    repeat (10) begin
      @(negedge clk);
      chk_bit("hdr_ready_blocked", s_eth_hdr_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    s_eth_hdr_valid = 1'b0;
    arp_hdr_hold = 1'b0;
    send_frame(16'h0800, 12, 1'b0, -1);

    send_frame(16'h0800, 20, 1'b0, 5);
    send_frame(16'h0806, 16, 1'b0, -1);
    send_frame(16'h0800, 20, 1'b1, -1);

    // Random frames, including near-miss ethertypes
    repeat (14) begin
      case ($urandom_range(0, 4))
        0: typ = 16'h0806;
        1: typ = 16'h0800;
        2: typ = 16'h0806 ^ (16'h1 << $urandom_range(0, 15));
        3: typ = 16'h0800 ^ (16'h1 << $urandom_range(0, 15));
        default: typ = 16'($urandom);
      endcase
      send_frame(typ, $urandom_range(1, 30), 1'($urandom_range(0, 1)), -1);
    end

    // Drain and final accounting
    t = 0;
    while ((exp_arp_hdr_q.size() + exp_ip_hdr_q.size() + exp_arp_q.size() + exp_ip_q.size()) != 0
           && t < 500) begin
      @(posedge clk);
      t++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_vec("arp_hdr_left", 112'(exp_arp_hdr_q.size()), 112'(0));
    chk_vec("ip_hdr_left", 112'(exp_ip_hdr_q.size()), 112'(0));
    chk_vec("arp_beats_left", 112'(exp_arp_q.size()), 112'(0));
    chk_vec("ip_beats_left", 112'(exp_ip_q.size()), 112'(0));
    chk_vec("drop_count", 112'(drop_seen), 112'(drop_exp));
    report();
  end

endmodule
